icache_param_core: RTL

Parametrised successor to the fixed 16-bit, 4-way instruction cache.
- Set-associative, blocking, read-only instruction cache; sets, ways, block size, word and memory-beat widths are all parameters.
- Sits between fetch (request/ready/valid) and the instruction memory interface (address/request, multi-beat data).
- Replacement uses per-way use bits (NRU). A miss refills the line in multiple beats, then returns the missed word.

---
 rtl/icache_param_core.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/icache_param_core.sv
// Parametrised set-associative blocking read-only instruction cache with NRU replacement.
// Optional build macro ICACHE_EARLY_RESTART_EN returns the missed word as soon as its beat lands.
module icache_param_core #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned WORD_WIDTH     = 20,
    parameter int unsigned NUM_SETS       = 16,
    parameter int unsigned NUM_WAYS       = 4,
    parameter int unsigned BLOCK_WORDS    = 16,
    parameter int unsigned MEM_DATA_WIDTH = 40
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      i_halt,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic [WORD_WIDTH-1:0]     o_data,
    output logic                      o_valid,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic                      o_mem_req_valid,
    input  logic [MEM_DATA_WIDTH-1:0] i_mem_data,
    input  logic                      i_mem_data_valid,
    output logic                      o_mem_if_ready
);
    localparam int unsigned OFF   = $clog2(BLOCK_WORDS);
    localparam int unsigned SET   = $clog2(NUM_SETS);
    localparam int unsigned TAG   = ADDR_WIDTH - OFF - SET;
    localparam int unsigned WPB   = MEM_DATA_WIDTH / WORD_WIDTH;
    localparam int unsigned BEATS = BLOCK_WORDS / WPB;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {StIdle, StMreq, StFill, StResp} state_e;

    state_e                  state;
    logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]     use_q   [NUM_SETS];
    logic [TAG-1:0]          tag_q   [NUM_SETS][NUM_WAYS];
    logic [WORD_WIDTH-1:0]   data_q  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];

    logic [TAG-1:0]   miss_tag;
    logic [SET-1:0]   miss_set;
    logic [OFF-1:0]   miss_off;
    logic [WAY_W-1:0] miss_way;
    logic [BW-1:0]    beat_cnt;

    logic [TAG-1:0]   req_tag;
    logic [SET-1:0]   req_set;
    logic [OFF-1:0]   req_off;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             victim_found;
    logic             beat_acc;
    logic             last_beat;
    logic             beat_has_miss;
    int unsigned      word_sel;
    logic [WORD_WIDTH-1:0] beat_word;

    assign {req_tag, req_set, req_off} = i_addr;

    assign o_ready         = (state == StIdle) & ~i_halt;
    assign o_mem_req_valid = (state == StMreq) & ~i_halt;
    assign o_mem_if_ready  = (state == StFill) & ~i_halt;
    assign beat_acc        = o_mem_if_ready & i_mem_data_valid;
    assign last_beat       = (beat_cnt == BW'(BEATS - 1));

    // Set the way's use bit; if that would saturate the set, keep only this way's bit.
    function automatic logic [NUM_WAYS-1:0] use_next(input logic [NUM_WAYS-1:0] cur,
                                                     input logic [WAY_W-1:0]    way);
        logic [NUM_WAYS-1:0] onehot;
        onehot = NUM_WAYS'(1) << way;
        return (&(cur | onehot)) ? onehot : (cur | onehot);
    endfunction

    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!victim_found && !valid_q[req_set][w]) begin
                victim       = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!victim_found && !use_q[req_set][w]) begin
                victim       = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
    end

    always_comb begin
        word_sel      = 32'(miss_off) % WPB;
        beat_word     = i_mem_data[word_sel*WORD_WIDTH +: WORD_WIDTH];
        beat_has_miss = ((32'(miss_off) / WPB) == 32'(beat_cnt));
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= StIdle;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_mem_addr <= '0;
            beat_cnt   <= '0;
            miss_tag   <= '0;
            miss_set   <= '0;
            miss_off   <= '0;
            miss_way   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                use_q[s]   <= '0;
            end
        end else if (!i_halt) begin
            o_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (i_valid) begin
                        if (hit) begin
                            o_valid        <= 1'b1;
                            o_data         <= data_q[req_set][hit_way][req_off];
                            use_q[req_set] <= use_next(use_q[req_set], hit_way);
                        end else begin
                            miss_tag   <= req_tag;
                            miss_set   <= req_set;
                            miss_off   <= req_off;
                            miss_way   <= victim;
                            o_mem_addr <= {req_tag, req_set, {OFF{1'b0}}};
                            state      <= StMreq;
                        end
                    end
                end
                StMreq: begin
                    valid_q[miss_set][miss_way] <= 1'b0;
                    state                       <= StFill;
                end
                StFill: begin
                    if (i_mem_data_valid) begin
`ifdef ICACHE_EARLY_RESTART_EN
                        if (beat_has_miss) begin
                            o_valid <= 1'b1;
                            o_data  <= beat_word;
                        end
`endif
                        if (last_beat) begin
                            beat_cnt                    <= '0;
                            valid_q[miss_set][miss_way] <= 1'b1;
                            use_q[miss_set]             <= use_next(use_q[miss_set], miss_way);
`ifdef ICACHE_EARLY_RESTART_EN
                            state <= StIdle;
`else
                            // The missed word may sit in this last beat, not yet in the array.
                            o_valid <= 1'b1;
                            o_data  <= beat_has_miss ? beat_word
                                                     : data_q[miss_set][miss_way][miss_off];
                            state   <= StResp;
`endif
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                StResp: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (beat_acc) begin
            for (int k = 0; k < WPB; k++) begin
                data_q[miss_set][miss_way][OFF'(32'(beat_cnt) * WPB + 32'(k))] <=
                    i_mem_data[k*WORD_WIDTH +: WORD_WIDTH];
            end
            if (last_beat) begin
                tag_q[miss_set][miss_way] <= miss_tag;
            end
        end
    end

endmodule
